// File: rtl/alu_operand_sequencer_pkg.sv
// Shared definitions for the ALU operand sequencer.
// Holds the FSM state encodings and the default operand width.
package alu_operand_sequencer_pkg;

    localparam int BITS_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        EXEC   = 2'd2,
        SHOW   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/step_edge_sync.sv
// Push-button synchronizer and rising-edge detector.
// Ports: clk, rst (async active-high), in (raw level),
//        pulse (one clk cycle per synchronized rising edge).
module step_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulse
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // r_s3 remembers the previous synchronized level, so a held
    // button yields exactly one pulse.
    assign pulse = r_s2 & ~r_s3;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Steps operand A, operand B, one-cycle capture and display of an
// external subtracter result, advanced by a push button.
// Ports: clk, rst (async active-high), step (raw button), din (switches),
//        alu_s/alu_c/alu_ovf (subtracter), op_a/op_b (to subtracter),
//        res, flag_c, flag_ovf, flag_zero, res_valid, state (LEDs).
module alu_operand_sequencer
    import alu_operand_sequencer_pkg::*;
#(
    parameter int bits_width = BITS_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  step,
    input  logic [bits_width-1:0] din,
    input  logic [bits_width-1:0] alu_s,
    input  logic                  alu_c,
    input  logic                  alu_ovf,
    output logic [bits_width-1:0] op_a,
    output logic [bits_width-1:0] op_b,
    output logic [bits_width-1:0] res,
    output logic                  flag_c,
    output logic                  flag_ovf,
    output logic                  flag_zero,
    output logic                  res_valid,
    output logic [1:0]            state
);

    seq_state_t r_state;
    seq_state_t w_state_nxt;

    logic                  w_pulse;
    logic                  w_load_a;
    logic                  w_load_b;
    logic                  w_capture;
    logic                  w_clear;

    logic [bits_width-1:0] r_op_a;
    logic [bits_width-1:0] r_op_b;
    logic [bits_width-1:0] r_res;
    logic                  r_flag_c;
    logic                  r_flag_ovf;
    logic                  r_flag_zero;
    logic                  r_res_valid;

    step_edge_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .in    (step),
        .pulse (w_pulse)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LOAD_A;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // EXEC advances without looking at the pulse, so a press
    // landing there is dropped rather than queued.
    always_comb begin
        w_state_nxt = r_state;
        w_load_a    = 1'b0;
        w_load_b    = 1'b0;
        w_capture   = 1'b0;
        w_clear     = 1'b0;
        unique case (r_state)
            LOAD_A: begin
                if (w_pulse) begin
                    w_load_a    = 1'b1;
                    w_state_nxt = LOAD_B;
                end
            end
            LOAD_B: begin
                if (w_pulse) begin
                    w_load_b    = 1'b1;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                w_capture   = 1'b1;
                w_state_nxt = SHOW;
            end
            SHOW: begin
                if (w_pulse) begin
                    w_clear     = 1'b1;
                    w_state_nxt = LOAD_A;
                end
            end
            default: w_state_nxt = LOAD_A;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_res       <= '0;
            r_flag_c    <= 1'b0;
            r_flag_ovf  <= 1'b0;
            r_flag_zero <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            if (w_load_a) begin
                r_op_a <= din;
            end
            if (w_load_b) begin
                r_op_b <= din;
            end
            if (w_capture) begin
                r_res       <= alu_s;
                r_flag_c    <= alu_c;
                r_flag_ovf  <= alu_ovf;
                r_flag_zero <= (alu_s == '0);
                r_res_valid <= 1'b1;
            end else if (w_clear) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign op_a      = r_op_a;
    assign op_b      = r_op_b;
    assign res       = r_res;
    assign flag_c    = r_flag_c;
    assign flag_ovf  = r_flag_ovf;
    assign flag_zero = r_flag_zero;
    assign res_valid = r_res_valid;
    assign state     = r_state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench for alu_operand_sequencer with a behavioural
// subtracter and a press-level reference model.
module tb_alu_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       step = 1'b0;
    logic [3:0] din = 4'h0;
    logic [3:0] alu_s;
    logic       alu_c;
    logic       alu_ovf;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic [3:0] res;
    logic       flag_c;
    logic       flag_ovf;
    logic       flag_zero;
    logic       res_valid;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    // Reference model of what the user should see.
    int         m_phase = 0;
    logic [3:0] m_a = 0;
    logic [3:0] m_b = 0;
    logic [3:0] m_res = 0;
    logic       m_c = 0;
    logic       m_ovf = 0;
    logic       m_z = 0;
    logic       m_valid = 0;

    always #5 clk = ~clk;

    // External subtracter stand-in.
    assign alu_s   = op_a - op_b;
    assign alu_c   = (op_a < op_b);
    assign alu_ovf = (op_a[3] != op_b[3]) && (alu_s[3] != op_a[3]);

    alu_operand_sequencer #(.bits_width(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .step      (step),
        .din       (din),
        .alu_s     (alu_s),
        .alu_c     (alu_c),
        .alu_ovf   (alu_ovf),
        .op_a      (op_a),
        .op_b      (op_b),
        .res       (res),
        .flag_c    (flag_c),
        .flag_ovf  (flag_ovf),
        .flag_zero (flag_zero),
        .res_valid (res_valid),
        .state     (state)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_press(input logic [3:0] v);
        int sa;
        int sb;
        int d;
        case (m_phase)
            0: begin
                m_a     = v;
                m_phase = 1;
            end
            1: begin
                m_b   = v;
                sa    = m_a[3] ? int'(m_a) - 16 : int'(m_a);
                sb    = m_b[3] ? int'(m_b) - 16 : int'(m_b);
                d     = sa - sb;
                m_res = 4'(int'(m_a) - int'(m_b));
                m_c   = (int'(m_a) < int'(m_b));
                m_ovf = (d > 7) || (d < -8);
                m_z   = (m_res == 0);
                m_valid = 1;
                m_phase = 3;
            end
            default: begin
                m_valid = 0;
                m_phase = 0;
            end
        endcase
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"}, 32'(state), 32'(m_phase));
        chk({tag, ".op_a"}, 32'(op_a), 32'(m_a));
        chk({tag, ".op_b"}, 32'(op_b), 32'(m_b));
        chk({tag, ".valid"}, 32'(res_valid), 32'(m_valid));
        chk({tag, ".res"}, 32'(res), 32'(m_res));
        chk({tag, ".c"}, 32'(flag_c), 32'(m_c));
        chk({tag, ".ovf"}, 32'(flag_ovf), 32'(m_ovf));
        chk({tag, ".z"}, 32'(flag_zero), 32'(m_z));
    endtask

    // Hold step for 'hold' cycles (>=3), then release for 4.
    // The din present at the 3rd rising edge is the one consumed.
    task automatic press(input int hold, input bit toggle,
                         input logic [3:0] val);
        logic [3:0] seen;
        seen = val;
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            step = 1'b1;
            din  = toggle ? 4'($urandom) : val;
            if (c == 2) seen = din;
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            step = 1'b0;
            if (toggle) din = 4'($urandom);
        end
        model_press(seen);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_phase = 0; m_a = 0; m_b = 0; m_res = 0;
        m_c = 0; m_ovf = 0; m_z = 0; m_valid = 0;
    endtask

    initial begin
        int pulses;
        int moves;
        logic [1:0] prev;

        // Reset state, before any clock edge
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // A=3, B=5
        press(3, 1'b0, 4'd3);
        press(4, 1'b0, 4'd5);
        check_all("3m5");
        chk("3m5.res_lit", 32'(res), 32'hE);
        chk("3m5.c_lit", 32'(flag_c), 32'd1);
        press(3, 1'b0, 4'd0);
        check_all("3m5.ack");

        // A=8, B=1 signed overflow
        press(3, 1'b0, 4'h8);
        press(3, 1'b0, 4'h1);
        check_all("8m1");
        chk("8m1.ovf_lit", 32'(flag_ovf), 32'd1);
        chk("8m1.res_lit", 32'(res), 32'h7);
        press(3, 1'b0, 4'd0);

        // A=5, B=5 zero
        press(3, 1'b0, 4'd5);
        press(3, 1'b0, 4'd5);
        check_all("5m5");
        chk("5m5.z_lit", 32'(flag_zero), 32'd1);
        press(3, 1'b0, 4'd0);
        check_all("5m5.ack");
        chk("5m5.ack_res", 32'(res), 32'd0);

        // Held 20 cycles in LOAD_A: one pulse, one transition
        pulses = 0;
        moves  = 0;
        prev   = state;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            step = 1'b1;
            din  = 4'h9;
            if (dut.u_sync.pulse) pulses++;
            if (state != prev) moves++;
            prev = state;
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            step = 1'b0;
            if (dut.u_sync.pulse) pulses++;
            if (state != prev) moves++;
            prev = state;
        end
        model_press(4'h9);
        chk("hold.pulses", 32'(pulses), 32'd1);
        chk("hold.moves", 32'(moves), 32'd1);
        check_all("hold");

        // Async reset in LOAD_B with op_a=7, no clock edge needed
        do_reset();
        press(3, 1'b0, 4'd7);
        chk("rstB.pre_a", 32'(op_a), 32'd7);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rstB.op_a", 32'(op_a), 32'd0);
        chk("rstB.state", 32'(state), 32'd0);
        chk("rstB.valid", 32'(res_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        m_phase = 0; m_a = 0; m_b = 0; m_res = 0;
        m_c = 0; m_ovf = 0; m_z = 0; m_valid = 0;
        check_all("rstB.after");

        // din toggling between and during presses
        for (int i = 0; i < 6; i++) begin
            press(3 + (i % 3), 1'b1, 4'h0);
            check_all("toggle");
        end

        // Randomized sequence against the model
        for (int i = 0; i < 30; i++) begin
            press(int'($urandom_range(3, 7)), 1'($urandom),
                  4'($urandom));
            check_all("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected done");
        $fatal(1, "timeout");
    end

endmodule
